toggle_sequencer: RTL and testbench

//  Controller and arbiter for the shared toggle datapath (en in; q, z out).

---
 rtl/toggle_sequencer_if.sv | 31 +++
 rtl/toggle_sequencer.sv | 159 +++++++++++++++
 tb/tb_toggle_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/toggle_sequencer_if.sv
// Bundle of the request/grant and toggle-datapath signals shared between the
// requesters, the toggle datapath and the sequencer.
interface toggle_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               en;
    logic               q;
    logic               z;
    logic               busy;
    logic               done;
    logic [ID_W-1:0]    done_id;
    logic               err;
    logic [CNT_W-1:0]   err_count;

    // requesters plus datapath side
    modport master (
        output req, q, z,
        input  gnt, en, busy, done, done_id, err, err_count
    );

    // sequencer side
    modport slave (
        input  req, q, z,
        output gnt, en, busy, done, done_id, err, err_count
    );
endinterface

// File: rtl/toggle_sequencer.sv
// Round-robin arbiter and operation sequencer for the shared toggle datapath.
// Every output is registered; nothing combinational from req/q/z reaches a pin.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates at every edge
// ACTIVE | grant cycle, en rises, q is sampled at its end
// CHECK  | en held while the response latency counts down, z sampled at the end
// GAP    | en low, done/err pulse in the first cycle, then idle spacing
module toggle_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 1,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    toggle_sequencer_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, CHECK, GAP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    winner, winner_nxt;
    logic [1:0]         wait_cnt, wait_nxt;
    logic [3:0]         gap_cnt, gap_nxt;

    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic               en_q, en_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               err_q, err_nxt;
    logic [ID_W-1:0]    done_id_q, done_id_nxt;
    logic [CNT_W-1:0]   err_count_q;

    logic               arb_hit;
    logic [ID_W-1:0]    arb_idx;

    // Round-robin search starting one past the last winner.
    always_comb begin
        int cand;
        arb_hit = 1'b0;
        arb_idx = ptr;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!arb_hit && bus.req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand[ID_W-1:0];
            end
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        winner_nxt  = winner;
        wait_nxt    = wait_cnt;
        gap_nxt     = gap_cnt;
        gnt_nxt     = '0;
        en_nxt      = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        done_id_nxt = '0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    state_nxt  = ACTIVE;
                    ptr_nxt    = arb_idx;
                    winner_nxt = arb_idx;
                    gnt_nxt    = NUM_REQ'(1) << arb_idx;
                    en_nxt     = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            ACTIVE: begin
                state_nxt = CHECK;
                wait_nxt  = bus.q ? 2'd1 : 2'd2;
                en_nxt    = 1'b1;
                busy_nxt  = 1'b1;
            end
            CHECK: begin
                busy_nxt = 1'b1;
                if (wait_cnt == 2'd1) begin
                    // the done cycle doubles as the first gap cycle
                    done_nxt    = 1'b1;
                    err_nxt     = ~bus.z;
                    done_id_nxt = winner;
                    if (MIN_GAP > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = 4'(MIN_GAP);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wait_nxt = wait_cnt - 2'd1;
                    en_nxt   = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt  = gap_cnt - 4'd1;
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            winner    <= '0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            done_id_q <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            wait_cnt  <= wait_nxt;
            gap_cnt   <= gap_nxt;
            gnt_q     <= gnt_nxt;
            en_q      <= en_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            done_id_q <= done_id_nxt;
        end
    end

    // Saturating error counter, updated on the same edge that raises err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_q <= '0;
        end else if (err_nxt && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.done_id   = done_id_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_toggle_sequencer.sv
// Bench for toggle_sequencer: a 4-requester instance with gap 1 and a
// 2-requester instance with gap 0 and a 2-bit error counter.
module tb_toggle_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    // reference model state
    int last_win = 3;
    int errs = 0;

    toggle_sequencer_if #(.NUM_REQ(4), .CNT_W(8)) bus1 ();
    toggle_sequencer_if #(.NUM_REQ(2), .CNT_W(2)) bus2 ();

    toggle_sequencer #(.NUM_REQ(4), .MIN_GAP(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    toggle_sequencer #(.NUM_REQ(2), .MIN_GAP(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        bus1.req = '0; bus1.q = 1'b0; bus1.z = 1'b0;
        bus2.req = '0; bus2.q = 1'b0; bus2.z = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus1.gnt !== 4'b0) $display("FAIL reset_gnt got %b want 0000", bus1.gnt); else passes++;
        checks++; if (bus1.en !== 1'b0) $display("FAIL reset_en got %b want 0", bus1.en); else passes++;
        checks++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus1.busy); else passes++;
        checks++; if (bus1.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus1.done); else passes++;
        checks++; if (bus1.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus1.err); else passes++;
        checks++; if (bus1.err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", bus1.err_count); else passes++;
        checks++; if (bus2.gnt !== 2'b0) $display("FAIL reset_gnt2 got %b want 00", bus2.gnt); else passes++;
        reset = 1'b1;
        last_win = 3;
        errs = 0;
    endtask

    // All four requesters held: grants rotate 0,1,2,3,0 four cycles apart.
    task automatic test_back_to_back();
        int t;
        int prev;
        int w;
        bus1.req = 4'b1111; bus1.q = 1'b1; bus1.z = 1'b1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (bus1.gnt == 4'b0 && t < 20);
            w = rr_pick(bus1.req, last_win);
            checks++; if (bus1.gnt !== (4'b0001 << w)) $display("FAIL b2b_gnt op %0d got %b want %b", n, bus1.gnt, 4'b0001 << w); else passes++;
            if (n > 0) begin
                checks++; if (cyc - prev !== 4) $display("FAIL b2b_spacing op %0d got %0d want 4", n, cyc - prev); else passes++;
            end
            prev = cyc;
            last_win = w;
            if (n == 4) bus1.req = 4'b0000;
            repeat (2) @(negedge clk);
            checks++; if (bus1.done !== 1'b1 || bus1.en !== 1'b0) $display("FAIL b2b_done_cycle op %0d got done=%b en=%b want done=1 en=0", n, bus1.done, bus1.en); else passes++;
        end
        @(negedge clk);
    endtask

    // Single operations, directed table first then random; each starts idle.
    task automatic test_ops(input bit rnd, input int n_ops);
        logic [3:0] dreq [3] = '{4'b0001, 4'b0100, 4'b0001};
        logic       dq   [3] = '{1'b1, 1'b0, 1'b1};
        logic       dz   [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] r;
        logic       qv, zv;
        int         w, lat, t;
        for (int i = 0; i < n_ops; i++) begin
            if (rnd) begin
                r  = 4'($urandom_range(1, 15));
                qv = 1'($urandom_range(0, 1));
                zv = 1'($urandom_range(0, 1));
            end else begin
                r = dreq[i]; qv = dq[i]; zv = dz[i];
            end
            bus1.req = r; bus1.q = qv; bus1.z = zv;
            @(negedge clk);
            w = rr_pick(r, last_win);
            lat = qv ? 1 : 2;
            checks++; if (bus1.gnt !== (4'b0001 << w)) $display("FAIL op_gnt op %0d got %b want %b", i, bus1.gnt, 4'b0001 << w); else passes++;
            checks++; if (bus1.en !== 1'b1) $display("FAIL op_en_t1 op %0d got %b want 1", i, bus1.en); else passes++;
            bus1.req = 4'b0000;
            last_win = w;
            t = 0;
            while (bus1.done !== 1'b1 && t < 6) begin @(negedge clk); t++; end
            checks++; if (t !== lat + 1) $display("FAIL op_latency op %0d got %0d want %0d", i, t, lat + 1); else passes++;
            errs += zv ? 0 : 1;
            checks++; if (bus1.done_id !== 2'(w)) $display("FAIL op_done_id op %0d got %0d want %0d", i, bus1.done_id, w); else passes++;
            checks++; if (bus1.err !== ~zv) $display("FAIL op_err op %0d got %b want %b", i, bus1.err, ~zv); else passes++;
            checks++; if (bus1.en !== 1'b0) $display("FAIL op_en_done op %0d got %b want 0", i, bus1.en); else passes++;
            checks++; if (bus1.err_count !== 8'(errs)) $display("FAIL op_err_count op %0d got %0d want %0d", i, bus1.err_count, errs); else passes++;
            @(negedge clk);
            checks++; if (bus1.busy !== 1'b0) $display("FAIL op_gap_end op %0d got busy=%b want 0", i, bus1.busy); else passes++;
        end
    endtask

    // Reset during CHECK aborts silently; arbitration restarts at requester 0.
    task automatic test_reset_mid();
        bus1.req = 4'b0001; bus1.q = 1'b0; bus1.z = 1'b1;
        @(negedge clk);
        bus1.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus1.en !== 1'b1) $display("FAIL mid_en_before got %b want 1", bus1.en); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus1.en !== 1'b0 || bus1.busy !== 1'b0) $display("FAIL mid_async got en=%b busy=%b want 0 0", bus1.en, bus1.busy); else passes++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus1.done !== 1'b0) $display("FAIL mid_no_done got %b want 0", bus1.done); else passes++;
        end
        reset = 1'b1;
        last_win = 3;
        errs = 0;
        bus1.req = 4'b1111;
        @(negedge clk);
        checks++; if (bus1.gnt !== 4'b0001) $display("FAIL mid_first_gnt got %b want 0001", bus1.gnt); else passes++;
        checks++; if (bus1.err_count !== 8'd0) $display("FAIL mid_err_count got %0d want 0", bus1.err_count); else passes++;
        bus1.req = 4'b0000;
        last_win = 0;
        repeat (4) @(negedge clk);
    endtask

    // Gap 0 instance: back-to-back failing ops, 2-bit counter saturates at 3.
    task automatic test_saturate();
        int t;
        int prev;
        int exp_cnt;
        bus2.req = 2'b01; bus2.q = 1'b1; bus2.z = 1'b0;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (bus2.gnt == 2'b0 && t < 20);
            checks++; if (bus2.gnt !== 2'b01) $display("FAIL sat_gnt op %0d got %b want 01", n, bus2.gnt); else passes++;
            if (n > 0) begin
                checks++; if (cyc - prev !== 3) $display("FAIL sat_spacing op %0d got %0d want 3", n, cyc - prev); else passes++;
            end
            prev = cyc;
            if (n == 4) bus2.req = 2'b00;
            repeat (2) @(negedge clk);
            exp_cnt = (n + 1 > 3) ? 3 : n + 1;
            checks++; if (bus2.done !== 1'b1 || bus2.err !== 1'b1) $display("FAIL sat_done_err op %0d got done=%b err=%b want 1 1", n, bus2.done, bus2.err); else passes++;
            checks++; if (bus2.err_count !== 2'(exp_cnt)) $display("FAIL sat_err_count op %0d got %0d want %0d", n, bus2.err_count, exp_cnt); else passes++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ops(1'b0, 3);
        test_ops(1'b1, 40);
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
